// File: rtl/wave_pkg.sv
// Shared types and default sizing for the DDS sample source.
// Waveform selector encoding matches the 2-bit command field from the UART decoder.
package wave_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'b00,
    TRI    = 2'b01,
    SQUARE = 2'b10,
    SAW    = 2'b11
  } wave_e;

  localparam int DEF_DATA_W     = 10;
  localparam int DEF_PHASE_W    = 24;
  localparam int DEF_LUT_ADDR_W = 8;

  function automatic int midscaleOf(input int width);
    return 2 ** (width - 1);
  endfunction

  localparam int MIDSCALE  = midscaleOf(DEF_DATA_W);
  localparam int FULLSCALE = 2 ** DEF_DATA_W - 1;

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table, round((2**(DATA_W-1)-1)*sin(pi/2*i/depth)), built at elaboration.
// Synchronous read with one cycle of latency.
module sine_quarter_rom
  import wave_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LUT_ADDR_W = DEF_LUT_ADDR_W
) (
  input  logic                  ipClk,
  input  logic [LUT_ADDR_W-1:0] ipAddr,
  output logic [DATA_W-2:0]     opData
);

  localparam real Pi    = 3.14159265358979323846;
  localparam int  Depth = 2 ** LUT_ADDR_W;
  localparam int  Amp   = 2 ** (DATA_W - 1) - 1;

  logic [DATA_W-2:0] romTable [Depth];

  for (genvar i = 0; i < Depth; i++) begin : gEntry
    localparam real Angle = Pi / 2.0 * i / Depth;
    assign romTable[i] = (DATA_W-1)'($rtoi(Amp * $sin(Angle) + 0.5));
  end

  // NOTE: ROM read register has no reset so it maps onto block RAM; downstream valids gate its output.
  always_ff @(posedge ipClk) begin
    opData <= romTable[ipAddr];
  end

endmodule

// File: rtl/wave_sample_gen.sv
// DDS sample source: phase accumulator stepped per DAC sync edge, 3-cycle pipeline to an
// offset-binary sine/triangle/square/sawtooth sample.
module wave_sample_gen
  import wave_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int LUT_ADDR_W = DEF_LUT_ADDR_W
) (
  input  logic               ipClk,
  input  logic               ipnReset,
  input  logic               ipSync,
  input  logic               ipEnable,
  input  logic               ipClearPhase,
  input  logic [1:0]         ipWave,
  input  logic [PHASE_W-1:0] ipPhaseInc,
  input  logic               ipIncLoad,
  output logic [DATA_W-1:0]  opData,
  output logic               opValid,
  output logic               opWrap
);

  // Only the top phase bits reach the waveform logic; sine needs LUT_ADDR_W+2 <= DATA_W+1 of them.
  localparam int SnapW = DATA_W + 1;
  localparam logic [DATA_W-1:0] MidScale = DATA_W'(midscaleOf(DATA_W));

  // Stage 0: edge detect, shadow registers, accumulator
  logic               syncD, accept, pending;
  logic [PHASE_W-1:0] phase, activeInc, shadowInc, effInc;
  logic [PHASE_W:0]   sum;
  wave_e              activeWave, shadowWave, effWave, wave0;
  logic [SnapW-1:0]   snap;
  logic               v0, wrap0;

  always_comb begin
    accept  = ipSync && !syncD && ipEnable && !ipClearPhase;
    effInc  = pending ? shadowInc : activeInc;
    effWave = pending ? shadowWave : activeWave;
    sum     = {1'b0, phase} + {1'b0, effInc};
  end

  // NOTE: non-blocking assignments make every register see pre-edge values, so a load
  // coincident with an accepted edge re-arms pending after the clear written above it.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      syncD      <= 1'b0;
      phase      <= '0;
      activeInc  <= '0;
      activeWave <= SINE;
      shadowInc  <= '0;
      shadowWave <= SINE;
      pending    <= 1'b0;
      snap       <= '0;
      wave0      <= SINE;
      wrap0      <= 1'b0;
      v0         <= 1'b0;
    end else begin
      syncD <= ipSync;
      v0    <= accept;
      if (ipClearPhase) phase <= '0;
      else if (accept)  phase <= sum[PHASE_W-1:0];
      if (accept) begin
        snap  <= phase[PHASE_W-1 -: SnapW];
        wrap0 <= sum[PHASE_W];
        wave0 <= effWave;
        if (pending) begin
          activeInc  <= shadowInc;
          activeWave <= shadowWave;
          pending    <= 1'b0;
        end
      end
      if (ipIncLoad && ipEnable) begin
        shadowInc  <= ipPhaseInc;
        shadowWave <= wave_e'(ipWave);
        pending    <= 1'b1;
      end
    end
  end

  // Stage 1: quadrant fold for the ROM address, non-sine waves computed directly
  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] idx, romAddr;
  logic [DATA_W:0]       triWord;
  logic [DATA_W-1:0]     altVal, alt1, alt2;
  logic                  neg1, neg2, v1, v2, wrap1, wrap2;
  wave_e                 wave1, wave2;

  assign quad    = snap[SnapW-1 -: 2];
  assign idx     = snap[SnapW-3 -: LUT_ADDR_W];
  assign triWord = snap[SnapW-1 -: DATA_W+1];

  // NOTE: default assigned first so no path through the case leaves altVal unassigned (no latch).
  always_comb begin
    altVal = '0;
    case (wave0)
      TRI:     altVal = triWord[DATA_W] ? ~triWord[DATA_W-1:0] : triWord[DATA_W-1:0];
      SQUARE:  altVal = snap[SnapW-1] ? '0 : '1;
      SAW:     altVal = snap[SnapW-1 -: DATA_W];
      default: altVal = '0;
    endcase
  end

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      romAddr <= '0;
      neg1    <= 1'b0;
      wave1   <= SINE;
      alt1    <= '0;
      v1      <= 1'b0;
      wrap1   <= 1'b0;
    end else begin
      romAddr <= quad[0] ? ~idx : idx;
      neg1    <= quad[1];
      wave1   <= wave0;
      alt1    <= altVal;
      v1      <= v0;
      wrap1   <= wrap0;
    end
  end

  // Stage 2: ROM read alongside the delayed side-band
  logic [DATA_W-2:0] romData;

  sine_quarter_rom #(
    .DATA_W     (DATA_W),
    .LUT_ADDR_W (LUT_ADDR_W)
  ) uRom (
    .ipClk  (ipClk),
    .ipAddr (romAddr),
    .opData (romData)
  );

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      neg2  <= 1'b0;
      wave2 <= SINE;
      alt2  <= '0;
      v2    <= 1'b0;
      wrap2 <= 1'b0;
    end else begin
      neg2  <= neg1;
      wave2 <= wave1;
      alt2  <= alt1;
      v2    <= v1;
      wrap2 <= wrap1;
    end
  end

  // Stage 3: sign the sine magnitude around midscale and register the output
  logic [DATA_W-1:0] romExt, sineVal;

  assign romExt  = {1'b0, romData};
  assign sineVal = neg2 ? MidScale - romExt : MidScale + romExt;

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      opData  <= MidScale;
      opValid <= 1'b0;
      opWrap  <= 1'b0;
    end else begin
      opValid <= v2;
      opWrap  <= v2 && wrap2;
      if (v2) opData <= (wave2 == SINE) ? sineVal : alt2;
    end
  end

endmodule

// File: tb/tb_wave_sample_gen.sv
// Self-checking bench: every cycle compares outputs with a reference model built from the
// waveform formulas, plus directed sample sequences and a randomized run.
module tb_wave_sample_gen;
  import wave_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int PW = DEF_PHASE_W;
  localparam longint unsigned PhaseMod = 64'd1 << PW;
  localparam real Pi = 3.14159265358979323846;

  logic          ipClk = 1'b0;
  logic          ipnReset = 1'b0;
  logic          ipSync = 1'b0;
  logic          ipEnable = 1'b0;
  logic          ipClearPhase = 1'b0;
  logic          ipIncLoad = 1'b0;
  logic [1:0]    ipWave = 2'b00;
  logic [PW-1:0] ipPhaseInc = '0;
  logic [DW-1:0] opData;
  logic          opValid, opWrap;

  wave_sample_gen dut (
    .ipClk        (ipClk),
    .ipnReset     (ipnReset),
    .ipSync       (ipSync),
    .ipEnable     (ipEnable),
    .ipClearPhase (ipClearPhase),
    .ipWave       (ipWave),
    .ipPhaseInc   (ipPhaseInc),
    .ipIncLoad    (ipIncLoad),
    .opData       (opData),
    .opValid      (opValid),
    .opWrap       (opWrap)
  );

  always #5 ipClk = ~ipClk;

  typedef struct {
    longint due;
    int     data;
    bit     wrap;
  } exp_t;

  exp_t   expQ[$];
  int     obsData[$];
  int     obsWrap[$];
  int     total = 0;
  int     bad = 0;
  longint edgeNo = 0;

  longint unsigned mPhase, mInc, mShInc;
  int mWave, mShWave, mData;
  bit mPending, mSyncD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, edgeNo);
    end
  endtask

  function automatic int romVal(input int i);
    return $rtoi(511.0 * $sin(Pi / 2.0 * i / 256.0) + 0.5);
  endfunction

  // Sample from the pre-increment phase, straight from the waveform definitions.
  function automatic int refSample(input longint unsigned ph, input int wave);
    int q, i, t;
    case (wave)
      0: begin
        q = int'(ph >> (PW - 2));
        i = int'((ph >> (PW - 10)) % 256);
        if (q % 2 == 1) i = 255 - i;
        return (q < 2) ? MIDSCALE + romVal(i) : MIDSCALE - romVal(i);
      end
      1: begin
        t = int'(ph >> (PW - 11));
        return (t >= 1024) ? 2047 - t : t;
      end
      2: return (ph >= (PhaseMod / 2)) ? 0 : FULLSCALE;
      default: return int'(ph >> (PW - 10));
    endcase
  endfunction

  task automatic modelReset();
    mPhase = 0; mInc = 0; mShInc = 0; mWave = 0; mShWave = 0;
    mPending = 0; mSyncD = 0; mData = MIDSCALE;
    expQ.delete();
  endtask

  // Advance the model for the coming edge, clock once, then compare away from the edge.
  task automatic tick();
    bit acc;
    longint unsigned nxt;
    if (ipnReset !== 1'b1) modelReset();
    else begin
      acc = ipSync && !mSyncD && ipEnable && !ipClearPhase;
      if (ipClearPhase) mPhase = 0;
      else if (acc) begin
        if (mPending) begin mInc = mShInc; mWave = mShWave; mPending = 0; end
        nxt = mPhase + mInc;
        expQ.push_back('{edgeNo + 4, refSample(mPhase, mWave), nxt >= PhaseMod});
        mPhase = nxt % PhaseMod;
      end
      if (ipIncLoad && ipEnable) begin
        mShInc = longint'(ipPhaseInc); mShWave = int'(ipWave); mPending = 1;
      end
      mSyncD = ipSync;
    end
    @(posedge ipClk);
    edgeNo++;
    #1;
    if (expQ.size() > 0 && expQ[0].due == edgeNo) begin
      check("valid", 32'(opValid), 32'd1);
      check("data", 32'(opData), 32'(expQ[0].data));
      check("wrap", 32'(opWrap), 32'(expQ[0].wrap));
      mData = expQ[0].data;
      void'(expQ.pop_front());
    end else begin
      check("valid_idle", 32'(opValid), 32'd0);
      check("data_hold", 32'(opData), 32'(mData));
      check("wrap_idle", 32'(opWrap), 32'd0);
    end
    if (opValid === 1'b1) begin
      obsData.push_back(int'(opData));
      obsWrap.push_back(int'(opWrap));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      ipSync = 1'b1; tick();
      ipSync = 1'b0; tick();
    end
  endtask

  task automatic load(input int inc, input int wave);
    ipPhaseInc = PW'(inc); ipWave = 2'(wave); ipIncLoad = 1'b1; tick();
    ipIncLoad = 1'b0;
  endtask

  task automatic clearPhase();
    ipClearPhase = 1'b1; tick();
    ipClearPhase = 1'b0;
  endtask

  // Compare the captured samples with a directed list; wrapMask bit k is sample k's wrap.
  task automatic expectObs(input string tag, input int n, input int d0, input int d1,
                           input int d2, input int d3, input int wrapMask);
    int d[4];
    d = '{d0, d1, d2, d3};
    check({tag, "_count"}, 32'(obsData.size()), 32'(n));
    for (int i = 0; i < n && i < obsData.size(); i++) begin
      check($sformatf("%s_s%0d", tag, i), 32'(obsData[i]), 32'(d[i]));
      check($sformatf("%s_w%0d", tag, i), 32'(obsWrap[i]), 32'((wrapMask >> i) & 1));
    end
    obsData.delete();
    obsWrap.delete();
  endtask

  initial begin
    modelReset();
    // Reset state held, then release with no requests
    idle(3);
    ipnReset = 1'b1;
    ipEnable = 1'b1;
    idle(4);
    check("reset_data", 32'(opData), 32'(MIDSCALE));

    // Reset while a sample is in flight: nothing emerges afterwards
    load(1 << 22, 0);
    clearPhase();
    ipSync = 1'b1; tick();
    ipSync = 1'b0;
    ipnReset = 1'b0;
    idle(2);
    ipnReset = 1'b1;
    idle(6);
    expectObs("flush", 0, 0, 0, 0, 0, 0);

    // Sine at a quarter-cycle step, requests every two cycles
    load(1 << 22, 0);
    clearPhase();
    pulse(4);
    idle(4);
    expectObs("sine", 4, 512, 1023, 512, 1, 4'b1000);

    // Square at half-cycle step
    load(1 << 23, 2);
    clearPhase();
    pulse(4);
    idle(4);
    expectObs("square", 4, 1023, 0, 1023, 0, 4'b1010);

    // Sawtooth at quarter-cycle step
    load(1 << 22, 3);
    clearPhase();
    pulse(4);
    idle(4);
    expectObs("saw", 4, 0, 256, 512, 768, 4'b1000);

    // Load coincident with an accepted edge: that step keeps the old increment
    load(1 << 22, 0);
    clearPhase();
    pulse(1);
    ipSync = 1'b1; ipPhaseInc = PW'(1 << 23); ipIncLoad = 1'b1; tick();
    ipSync = 1'b0; ipIncLoad = 1'b0; tick();
    pulse(2);
    idle(4);
    expectObs("incload", 4, 512, 1023, 512, 512, 4'b0100);

    // Clear coincident with a sync edge drops that edge
    ipClearPhase = 1'b1; ipSync = 1'b1; tick();
    ipClearPhase = 1'b0; ipSync = 1'b0; tick();
    idle(4);
    expectObs("clear_drop", 0, 0, 0, 0, 0, 0);
    pulse(1);
    idle(4);
    expectObs("after_clear", 1, 512, 0, 0, 0, 0);

    // Disabled: edges ignored, output held
    ipEnable = 1'b0;
    pulse(3);
    idle(4);
    expectObs("disabled", 0, 0, 0, 0, 0, 0);
    ipEnable = 1'b1;

    // Zero increment: identical samples, never a wrap
    load(0, 1);
    pulse(3);
    idle(4);
    check("inc0_count", 32'(obsData.size()), 32'd3);
    obsData.delete();
    obsWrap.delete();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ipSync       = 1'($urandom_range(0, 1));
      ipEnable     = ($urandom_range(0, 9) != 0);
      ipClearPhase = ipEnable && ($urandom_range(0, 29) == 0);
      ipIncLoad    = ipEnable && ($urandom_range(0, 19) == 0);
      ipPhaseInc   = PW'($urandom);
      ipWave       = 2'($urandom_range(0, 3));
      tick();
    end
    ipSync = 1'b0; ipIncLoad = 1'b0; ipClearPhase = 1'b0; ipEnable = 1'b1;
    idle(5);
    check("queue_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
